// File: rtl/gen_pad_poll.sv
// Genesis joystick-port poller: drives TH through an 8-phase read and decodes 3/6-button pads.
// Results commit atomically in DONE with a one-clock VALID; the frame pauses while CE=0.
module gen_pad_poll #(
  parameter int PHASE_TICKS = 8,
  parameter int IDLE_TICKS  = 2048
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        ENA,
  input  logic [7:0]  joy_in,
  output logic [7:0]  joy_out,
  output logic [7:0]  joy_ctl,
  output logic [11:0] BTN,
  output logic        PRESENT,
  output logic        SIX,
  output logic        VALID
);

  localparam int MAXT = (PHASE_TICKS > IDLE_TICKS) ? PHASE_TICKS : IDLE_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] PH_LAST   = CW'(PHASE_TICKS - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TICKS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PH0, S_PH1, S_PH2, S_PH3, S_PH4, S_PH5, S_PH6, S_PH7, S_DONE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_th, w_th_nxt;
  logic            w_sample, w_clear;
  logic [5:0]      w_d;
  logic [11:0]     r_s_btn;
  logic            r_pad_ok, r_six_ok;
  logic            w_unused;

  assign w_d      = ~joy_in[5:0];
  assign w_unused = ^joy_in[7:6];
  assign joy_out  = {1'b0, r_th, 6'b0};
  assign joy_ctl  = 8'h40;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_th    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_th    <= w_th_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sample    = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Counter saturates at IDLE_LAST so a late ENA starts the frame on the next tick.
        if (CE) begin
          if (r_cnt == IDLE_LAST) begin
            if (ENA) begin
              w_state_nxt = S_PH0;
              w_cnt_nxt   = '0;
              w_clear     = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        if (!ENA) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (CE) begin
          if (r_cnt == PH_LAST) begin
            w_sample    = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = (r_state == S_PH7) ? S_DONE : state_t'(r_state + 4'd1);
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
    endcase
    w_th_nxt = !(w_state_nxt == S_PH1 || w_state_nxt == S_PH3 ||
                 w_state_nxt == S_PH5 || w_state_nxt == S_PH7);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s_btn  <= '0;
      r_pad_ok <= 1'b0;
      r_six_ok <= 1'b0;
    end else if (w_clear) begin
      r_s_btn  <= '0;
      r_pad_ok <= 1'b0;
      r_six_ok <= 1'b0;
    end else if (w_sample) begin
      case (r_state)
        S_PH0: begin
          r_s_btn[3:0] <= w_d[3:0];
          r_s_btn[5]   <= w_d[4];
          r_s_btn[6]   <= w_d[5];
        end
        S_PH1: begin
          r_s_btn[4] <= w_d[4];
          r_s_btn[7] <= w_d[5];
          r_pad_ok   <= w_d[3] & w_d[2];
        end
        S_PH5: r_six_ok <= &w_d[3:0];
        S_PH6: begin
          if (r_six_ok) r_s_btn[11:8] <= {w_d[0], w_d[1], w_d[2], w_d[3]};
        end
        default: ;
      endcase
    end
  end

  // Results land on the edge entering DONE, so VALID and the new values appear together.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      BTN     <= '0;
      PRESENT <= 1'b0;
      SIX     <= 1'b0;
      VALID   <= 1'b0;
    end else begin
      VALID <= (w_state_nxt == S_DONE);
      if (w_state_nxt == S_DONE) begin
        PRESENT <= r_pad_ok;
        SIX     <= r_pad_ok & r_six_ok;
        if (!r_pad_ok)      BTN <= '0;
        else if (!r_six_ok) BTN <= {4'b0, r_s_btn[7:0]};
        else                BTN <= r_s_btn;
      end
    end
  end

endmodule

// File: tb/tb_gen_pad_poll.sv
// Directed bench for gen_pad_poll with a behavioural Genesis 3/6-button pad on the pins.
module tb_gen_pad_poll;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        CE;
  logic        ENA = 1'b0;
  logic [7:0]  joy_in;
  logic [7:0]  joy_out, joy_ctl;
  logic [11:0] BTN;
  logic        PRESENT, SIX, VALID;

  int n_chk = 0;
  int n_err = 0;

  gen_pad_poll #(.PHASE_TICKS(4), .IDLE_TICKS(16)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .ENA(ENA), .joy_in(joy_in),
    .joy_out(joy_out), .joy_ctl(joy_ctl), .BTN(BTN), .PRESENT(PRESENT),
    .SIX(SIX), .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  logic       ce_slow = 1'b0;
  logic [1:0] ce_ph = 2'd0;
  always @(posedge CLK) ce_ph <= ce_ph + 2'd1;
  assign CE = ce_slow ? (ce_ph == 2'd0) : 1'b1;

  // Pad model: pair index tracked from TH falling edges; a long TH-high restarts the sequence.
  logic        pad_on = 1'b1;
  logic        pad_six = 1'b0;
  logic [11:0] pb = 12'h000;
  int          tmo = 8;
  int          m_hi = 1000;
  int          m_k = 0;
  logic        th_prev = 1'b1;
  logic        th;
  int          p;
  logic [5:0]  d;

  always @(negedge CLK) begin
    if (joy_out[6]) begin
      if (m_hi < 100000) m_hi <= m_hi + 1;
    end else begin
      if (th_prev) m_k <= (m_hi > tmo) ? 1 : m_k + 1;
      m_hi <= 0;
    end
    th_prev <= joy_out[6];
  end

  always_comb begin
    th = joy_out[6];
    p  = th ? ((m_hi > tmo) ? 1 : m_k + 1) : m_k;
    d  = {pb[6], pb[5], pb[3], pb[2], pb[1], pb[0]};
    if (th && pad_six && p == 4) d = {pb[6], pb[5], pb[8], pb[9], pb[10], pb[11]};
    if (!th) begin
      d = {pb[7], pb[4], 2'b11, pb[1], pb[0]};
      if (pad_six && p == 3) d[3:0] = 4'hF;
      if (pad_six && p == 4) d[3:0] = 4'h0;
    end
    joy_in = pad_on ? {1'b1, th, ~d} : 8'hFF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [11:0] eb, input logic ep, input logic es);
    chk({tag, "_btn"}, 32'(BTN), 32'(eb));
    chk({tag, "_present"}, 32'(PRESENT), 32'(ep));
    chk({tag, "_six"}, 32'(SIX), 32'(es));
  endtask

  // Entered at a VALID negedge with CE every cycle; follows one full 49-cycle frame.
  task automatic frame_check(input string tag, input logic [11:0] eb, input logic ep, input logic es);
    int nv = 0;
    for (int i = 1; i <= 49; i++) begin
      @(negedge CLK);
      if (i == 8) chk({tag, "_th_idle"}, 32'(joy_out), 32'h40);
      if (i >= 17 && i <= 48 && ((i - 17) % 4) == 1)
        chk({tag, "_th_phase"}, 32'(joy_out), ((((i - 17) / 4) % 2) == 0) ? 32'h40 : 32'h00);
      if (i < 49 && VALID) nv++;
    end
    chk({tag, "_early_valid"}, 32'(nv), 32'd0);
    chk({tag, "_valid"}, 32'(VALID), 32'd1);
    chk({tag, "_th_done"}, 32'(joy_out), 32'h40);
    chk({tag, "_ctl"}, 32'(joy_ctl), 32'h40);
    chk_out(tag, eb, ep, es);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!VALID && n < max);
    chk("valid_timeout", 32'(VALID), 32'd1);
  endtask

  initial begin
    int nv;
    int n;

    repeat (3) @(negedge CLK);
    chk("rst_joy_out", 32'(joy_out), 32'h40);
    chk("rst_joy_ctl", 32'(joy_ctl), 32'h40);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk_out("rst", 12'h000, 1'b0, 1'b0);

    // 3-button pad, A+START+UP
    pb = 12'h091; pad_six = 1'b0; ENA = 1'b1;
    @(negedge CLK); RESET = 1'b0;
    nv = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge CLK);
      if (i < 48 && VALID) nv++;
    end
    chk("first_early_valid", 32'(nv), 32'd0);
    chk("first_valid", 32'(VALID), 32'd1);
    chk_out("first", 12'h091, 1'b1, 1'b0);
    frame_check("pad3", 12'h091, 1'b1, 1'b0);

    // 6-button pad, Z+X+B then X+MODE+C
    pb = 12'hA20; pad_six = 1'b1;
    frame_check("pad6a", 12'hA20, 1'b1, 1'b1);
    pb = 12'h340;
    frame_check("pad6b", 12'h340, 1'b1, 1'b1);

    // nothing plugged in
    pad_on = 1'b0;
    frame_check("nopad", 12'h000, 1'b0, 1'b0);
    pad_on = 1'b1; pb = 12'hA20;
    frame_check("pad6c", 12'hA20, 1'b1, 1'b1);

    // ENA dropped for one cycle in PH3
    pb = 12'h091; pad_six = 1'b0;
    for (int i = 1; i <= 30; i++) @(negedge CLK);
    chk("ph3_th", 32'(joy_out), 32'h00);
    ENA = 1'b0;
    @(negedge CLK);
    chk("abort_th", 32'(joy_out), 32'h40);
    chk("abort_valid", 32'(VALID), 32'd0);
    ENA = 1'b1;
    nv = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge CLK);
      if (i < 48 && VALID) nv++;
      if (i == 47) chk("abort_btn_held", 32'(BTN), 32'hA20);
    end
    chk("abort_early_valid", 32'(nv), 32'd0);
    chk("abort_valid_after", 32'(VALID), 32'd1);
    chk_out("abort", 12'h091, 1'b1, 1'b0);

    // ENA held low through idle: counter saturates, frame starts on the next tick after ENA
    pb = 12'hA20; pad_six = 1'b1; ENA = 1'b0;
    nv = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (VALID) nv++;
    end
    ENA = 1'b1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge CLK);
      if (i < 33 && VALID) nv++;
    end
    chk("sat_early_valid", 32'(nv), 32'd0);
    chk("sat_valid", 32'(VALID), 32'd1);
    chk_out("sat", 12'hA20, 1'b1, 1'b1);

    // CE one cycle in four
    ce_slow = 1'b1; tmo = 32;
    wait_valid(400, n);
    chk_out("slow0", 12'hA20, 1'b1, 1'b1);
    wait_valid(400, n);
    chk("slow_period_a", 32'(n), 32'd192);
    chk_out("slow1", 12'hA20, 1'b1, 1'b1);
    pb = 12'h091; pad_six = 1'b0;
    wait_valid(400, n);
    chk("slow_period_b", 32'(n), 32'd192);
    chk_out("slow2", 12'h091, 1'b1, 1'b0);

    // back to full rate, then RESET in PH6 of a 6-button frame
    ce_slow = 1'b0; tmo = 8; pb = 12'hA20; pad_six = 1'b1;
    frame_check("fast", 12'hA20, 1'b1, 1'b1);
    for (int i = 1; i <= 42; i++) @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst6_joy_out", 32'(joy_out), 32'h40);
    chk("rst6_valid", 32'(VALID), 32'd0);
    chk_out("rst6", 12'h000, 1'b0, 1'b0);
    @(negedge CLK); RESET = 1'b0;
    nv = 0;
    for (int i = 1; i <= 48; i++) begin
      @(negedge CLK);
      if (i < 48 && VALID) nv++;
    end
    chk("rst6_early_valid", 32'(nv), 32'd0);
    chk("rst6_valid_after", 32'(VALID), 32'd1);
    chk_out("rst6_after", 12'hA20, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
